// File: rtl/regs_arbiter_if.sv
// Client-side bundle for regs_arbiter: per-client request fields plus the shared
// ack/done/rdata/busy return path.
interface regs_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) ();

  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    ack;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  ack, done, rdata, busy
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output ack, done, rdata, busy
  );

endinterface

// File: rtl/regs_arbiter.sv
// Two-client arbiter/sequencer for the register file write port and read port A.
// Define REGS_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties); default is round-robin.
module regs_arbiter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          CLK,
  input  logic          Reset,
  regs_arbiter_if.slave bus,
  output logic          reg_we,
  output logic [AW-1:0] reg_waddr,
  output logic [DW-1:0] reg_wdata,
  output logic [AW-1:0] reg_raddr_a,
  input  logic [DW-1:0] reg_rdata_a
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          reg_we_q, reg_we_d;
  logic [AW-1:0] reg_waddr_q, reg_waddr_d;
  logic [DW-1:0] reg_wdata_q, reg_wdata_d;
  logic [AW-1:0] reg_raddr_q, reg_raddr_d;
  logic [1:0]    ack_c;
  logic          winner;
  logic          take;
  logic          tie_pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef REGS_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  logic last_q, last_d;

  // Client not granted last wins a tie.
  assign tie_pick = ~last_q;
`endif

  always_comb begin
    winner = 1'b0;
    if (bus.req[0] && bus.req[1]) begin
      winner = tie_pick;
    end else if (bus.req[1]) begin
      winner = 1'b1;
    end
  end

  assign sel_we    = bus.we[winner];
  assign sel_addr  = winner ? bus.addr1 : bus.addr0;
  assign sel_wdata = winner ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    rdata_d     = rdata_q;
    reg_we_d    = 1'b0;
    reg_waddr_d = '0;
    reg_wdata_d = '0;
    reg_raddr_d = '0;
    ack_c       = 2'b00;
    take        = 1'b0;
`ifndef REGS_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif

    case (state_q)
      StIdle: begin
        take = |bus.req;
      end
      StAccess: begin
        state_d = StResp;
        done_d  = gnt_q ? 2'b10 : 2'b01;
        if (!reg_we_q) begin
          rdata_d = reg_rdata_a;
        end
      end
      StResp: begin
        state_d = StIdle;
        take    = |bus.req;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Accepting a request latches the winner's fields straight into the port registers.
    if (take) begin
      state_d = StAccess;
      gnt_d   = winner;
      ack_c   = winner ? 2'b10 : 2'b01;
`ifndef REGS_ARB_FIXED_PRIO_EN
      last_d  = winner;
`endif
      if (sel_we) begin
        reg_we_d    = 1'b1;
        reg_waddr_d = sel_addr;
        reg_wdata_d = sel_wdata;
      end else begin
        reg_raddr_d = sel_addr;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 2'b00;
      rdata_q     <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      reg_raddr_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_raddr_q <= reg_raddr_d;
    end
  end

`ifndef REGS_ARB_FIXED_PRIO_EN
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Reset gates ack so a held request is not acknowledged while the block is cleared.
  assign bus.ack   = ack_c & {2{Reset}};
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

  assign reg_we      = reg_we_q;
  assign reg_waddr   = reg_waddr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_raddr_a = reg_raddr_q;

endmodule

// File: tb/tb_regs_arbiter.sv
// Self-checking bench for regs_arbiter: directed scenarios plus randomized clients,
// checked every cycle against a transaction-level model with its own register image.
module tb_regs_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          reg_we;
  logic [AW-1:0] reg_waddr;
  logic [DW-1:0] reg_wdata;
  logic [AW-1:0] reg_raddr_a;
  logic [DW-1:0] reg_rdata_a;

  regs_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  regs_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK         (clk),
    .Reset       (rst_n),
    .bus         (bus),
    .reg_we      (reg_we),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .reg_raddr_a (reg_raddr_a),
    .reg_rdata_a (reg_rdata_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in register file driven by the DUT.
  logic [DW-1:0] tb_mem [32];
  always @(posedge clk) if (reg_we) tb_mem[reg_waddr] = reg_wdata;
  assign reg_rdata_a = tb_mem[reg_raddr_a];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [DW-1:0] exp_mem [32];
  int            t        = 0;
  int            last_acc = -100;
  bit            m_ptr    = 1'b1;
  bit            op_we;
  bit            op_gnt;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  logic [DW-1:0] m_rdata  = '0;

  function automatic bit pick(input logic [1:0] r, input bit ptr);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
`ifdef REGS_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return ~ptr;
`endif
  endfunction

  always @(negedge clk) begin
    bit            acc_ok, drv, rsp, w;
    logic [1:0]    e_ack, e_done;
    #1;
    if (!rst_n) begin
      last_acc = -100;
      m_ptr    = 1'b1;
      m_rdata  = '0;
      chk("rst_ack", {30'd0, bus.ack}, 32'd0);
      chk("rst_done", {30'd0, bus.done}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
      chk("rst_waddr", {27'd0, reg_waddr}, 32'd0);
      chk("rst_wdata", reg_wdata, 32'd0);
      chk("rst_raddr", {27'd0, reg_raddr_a}, 32'd0);
    end else begin
      acc_ok = (t >= last_acc + 2);
      drv    = (t == last_acc + 1);
      rsp    = (t == last_acc + 2);
      w      = pick(bus.req, m_ptr);
      e_ack  = (acc_ok && bus.req != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
      e_done = rsp ? (op_gnt ? 2'b10 : 2'b01) : 2'b00;
      chk("ack", {30'd0, bus.ack}, {30'd0, e_ack});
      chk("done", {30'd0, bus.done}, {30'd0, e_done});
      chk("busy", {31'd0, bus.busy}, {31'd0, drv || rsp});
      chk("rdata", bus.rdata, m_rdata);
      chk("reg_we", {31'd0, reg_we}, {31'd0, drv && op_we});
      chk("reg_waddr", {27'd0, reg_waddr}, (drv && op_we) ? {27'd0, op_addr} : 32'd0);
      chk("reg_wdata", reg_wdata, (drv && op_we) ? op_wdata : 32'd0);
      chk("reg_raddr_a", {27'd0, reg_raddr_a}, (drv && !op_we) ? {27'd0, op_addr} : 32'd0);
      if (drv) begin
        if (op_we) exp_mem[op_addr] = op_wdata;
        else       m_rdata = exp_mem[op_addr];
      end
      if (e_ack != 2'b00) begin
        last_acc = t;
        m_ptr    = w;
        op_gnt   = w;
        op_we    = bus.we[w];
        op_addr  = w ? bus.addr1 : bus.addr0;
        op_wdata = w ? bus.wdata1 : bus.wdata0;
      end
    end
    t++;
  end

  // ---------------- randomized clients ----------------
  bit         rand_en = 1'b0;
  logic [1:0] ack_seen;

  task automatic new_fields(input int i);
    bus.we[i] = 1'($urandom_range(1, 0));
    if (i == 0) begin
      bus.addr0  = 5'($urandom_range(7, 0));
      bus.wdata0 = $urandom;
    end else begin
      bus.addr1  = 5'($urandom_range(7, 0));
      bus.wdata1 = $urandom;
    end
  endtask

  always begin
    @(negedge clk);
    #2 ack_seen = bus.ack;
    @(posedge clk);
    #1;
    if (rand_en) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req[i]) begin
          if (ack_seen[i]) begin
            if ($urandom_range(1, 0) == 1) new_fields(i);
            else bus.req[i] = 1'b0;
          end
        end else if ($urandom_range(2, 0) == 0) begin
          bus.req[i] = 1'b1;
          new_fields(i);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         exp_w [4];
    logic [1:0] gack;
    rst_n      = 1'b0;
    bus.req    = 2'b00;
    bus.we     = 2'b00;
    bus.addr0  = '0;
    bus.addr1  = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i]  = $urandom;
      exp_mem[i] = tb_mem[i];
    end
    repeat (3) tick();
    rst_n = 1'b1;

    // Hazard: client 0 writes r7 while client 1 reads r7.
    tick();
    bus.req = 2'b11; bus.we = 2'b01;
    bus.addr0 = 5'd7; bus.wdata0 = 32'h003C_C381; bus.addr1 = 5'd7;
    mid(); chk("haz_ack0", {30'd0, bus.ack}, 32'd1);
    tick(); bus.req = 2'b10;
    mid(); chk("haz_we", {31'd0, reg_we}, 32'd1);
    tick();
    mid(); chk("haz_done0", {30'd0, bus.done}, 32'd1);
    chk("haz_ack1", {30'd0, bus.ack}, 32'd2);
    tick(); bus.req = 2'b00;
    mid(); chk("haz_raddr", {27'd0, reg_raddr_a}, 32'd7);
    tick();
    mid(); chk("haz_done1", {30'd0, bus.done}, 32'd2);
    chk("haz_rdata", bus.rdata, 32'h003C_C381);
    tick();

    // Single write then read of r3 by client 0.
    tick();
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 5'd3; bus.wdata0 = 32'h0000_0DB0;
    mid(); chk("wr_ack", {30'd0, bus.ack}, 32'd1);
    tick(); bus.req = 2'b00;
    mid(); chk("wr_reg_we", {31'd0, reg_we}, 32'd1);
    chk("wr_wdata", reg_wdata, 32'h0000_0DB0);
    tick(); bus.req = 2'b01; bus.we = 2'b00;
    mid(); chk("wr_done", {30'd0, bus.done}, 32'd1);
    chk("rd_ack", {30'd0, bus.ack}, 32'd1);
    tick(); bus.req = 2'b00;
    tick();
    mid(); chk("rd_done", {30'd0, bus.done}, 32'd1);
    chk("rd_rdata", bus.rdata, 32'h0000_0DB0);
    tick();

    // Back-to-back reads of r1..r4 by client 1.
    tick();
    bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 5'd1;
    mid();
    for (int k = 1; k <= 4; k++) begin
      chk("b2b_ack", {30'd0, bus.ack}, 32'd2);
      tick();
      bus.addr1 = 5'(k + 1);
      if (k == 4) bus.req = 2'b00;
      mid(); chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
      chk("b2b_raddr", {27'd0, reg_raddr_a}, 32'(k));
      tick();
      mid(); chk("b2b_done", {30'd0, bus.done}, 32'd2);
      chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    end
    tick();
    mid(); chk("b2b_idle", {31'd0, bus.busy}, 32'd0);

    // Continuous tie.
`ifdef REGS_ARB_FIXED_PRIO_EN
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    tick();
    bus.req = 2'b11; new_fields(0); new_fields(1);
    for (int g = 0; g < 4; g++) begin
      mid();
      gack = bus.ack;
      chk("tie_grant", {30'd0, gack}, exp_w[g] ? 32'd2 : 32'd1);
      tick();
      if (gack[1]) new_fields(1);
      else new_fields(0);
      tick();
    end
    bus.req = 2'b00;
    tick(); tick();

    // Reset in the ACCESS cycle of a write to r5.
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 5'd5; bus.wdata0 = 32'h1234_5678;
    tick(); bus.req = 2'b00;
    tick(); tick(); tick();
    bus.req = 2'b01; bus.wdata0 = 32'hFFFF_FFFF;
    tick(); bus.req = 2'b00;
    #1 rst_n = 1'b0;
    #1 chk("abort_reg_we", {31'd0, reg_we}, 32'd0);
    mid(); chk("abort_done", {30'd0, bus.done}, 32'd0);
    tick(); rst_n = 1'b1;
    tick();
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 5'd5;
    tick(); bus.req = 2'b00;
    tick();
    mid(); chk("abort_done_rd", {30'd0, bus.done}, 32'd1);
    chk("abort_rdata", bus.rdata, 32'h1234_5678);
    tick();

    // Randomized traffic.
    mid(); rand_en = 1'b1;
    repeat (3000) tick();
    mid(); rand_en = 1'b0;
    @(posedge clk); #2 bus.req = 2'b00;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
